// File: rtl/axi_top_pkg.sv
// Shared constants and types for the regex coprocessor: command/status codes,
// the instruction opcode set and the engine state encoding.
package axi_top_pkg;
  localparam int REG_WIDTH         = 32;
  localparam int INSTRUCTION_WIDTH = 16;

  localparam logic [REG_WIDTH-1:0] CMD_NOP                = 'd0;
  localparam logic [REG_WIDTH-1:0] CMD_WRITE              = 'd1;
  localparam logic [REG_WIDTH-1:0] CMD_START              = 'd2;
  localparam logic [REG_WIDTH-1:0] CMD_READ               = 'd3;
  localparam logic [REG_WIDTH-1:0] CMD_RESET              = 'd4;
  localparam logic [REG_WIDTH-1:0] CMD_READ_ELAPSED_CLOCK = 'd5;

  typedef enum logic [2:0] {
    STATUS_IDLE     = 3'd0,
    STATUS_ACCEPTED = 3'd1,
    STATUS_REJECTED = 3'd2,
    STATUS_ERROR    = 3'd3,
    STATUS_RUNNING  = 3'd4
  } status_e;

  typedef enum logic [2:0] {
    OP_ACCEPT         = 3'd0,
    OP_SPLIT          = 3'd1,
    OP_MATCH          = 3'd2,
    OP_JMP            = 3'd3,
    OP_END            = 3'd4,
    OP_MATCH_ANY      = 3'd5,
    OP_ACCEPT_PARTIAL = 3'd6,
    OP_NOT_MATCH      = 3'd7
  } opcode_e;

  typedef enum logic [2:0] {
    ST_FETCH_I, ST_WAIT_I, ST_FETCH_C, ST_WAIT_C, ST_EXEC
  } eng_state_e;

  typedef enum logic [2:0] {
    ACT_ADV, ACT_JMP, ACT_PUSH, ACT_FAIL, ACT_ACCEPT
  } act_e;

  // Only character-consuming opcodes pay for the extra char fetch.
  function automatic logic needs_char(opcode_e op);
    return (op == OP_MATCH) || (op == OP_MATCH_ANY) || (op == OP_NOT_MATCH);
  endfunction
endpackage

// File: rtl/regex_mem.sv
// Single-port word RAM shared by code and string; read data is registered and
// only updates on a read so it can double as the host read-back register.
module regex_mem #(
  parameter int WORDS = 1024,
  parameter int WIDTH = 32,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic             clk,
  input  logic             we,
  input  logic             re,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end
endmodule

// File: rtl/axi_top.sv
// Register-mapped regex coprocessor: host load/read port plus a backtracking
// engine that runs code from word 0 over a byte string in the same memory.
module axi_top
  import axi_top_pkg::*;
#(
  parameter int MEM_WORDS   = 1024,
  parameter int STACK_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_WIDTH-1:0] data_in_register,
  input  logic [REG_WIDTH-1:0] address_register,
  input  logic [REG_WIDTH-1:0] start_cc_pointer_register,
  input  logic [REG_WIDTH-1:0] end_cc_pointer_register,
  input  logic [REG_WIDTH-1:0] cmd_register,
  output logic [REG_WIDTH-1:0] status_register,
  output logic [REG_WIDTH-1:0] data_o_register
);
  localparam int AW = $clog2(MEM_WORDS);
  localparam int SW = $clog2(STACK_DEPTH);
  localparam int PW = $clog2(STACK_DEPTH + 1);
  localparam logic [PW-1:0] SP_FULL = PW'(STACK_DEPTH);

  typedef struct packed {
    logic [AW-1:0]        pc;
    logic [REG_WIDTH-1:0] cc;
  } bt_entry_t;

  status_e                      status;
  eng_state_e                   state;
  act_e                         act;
  logic [AW-1:0]                pc;
  logic [REG_WIDTH-1:0]         cc, elapsed, data_reg;
  logic [INSTRUCTION_WIDTH-1:0] instr;
  logic [7:0]                   ch;
  bt_entry_t                    stack [STACK_DEPTH];
  logic [PW-1:0]                sp, sp_dec;
  logic                         sel_mem, running, in_range;
  logic                         mem_we, mem_re;
  logic [AW-1:0]                mem_addr;
  logic [REG_WIDTH-1:0]         mem_rdata;
  opcode_e                      op;
  logic [12:0]                  operand;
  logic                         unused_bits;

  assign running  = (status == STATUS_RUNNING);
  assign op       = opcode_e'(instr[15:13]);
  assign operand  = instr[12:0];
  assign in_range = (cc <= end_cc_pointer_register);
  assign sp_dec   = sp - 1'b1;
  assign unused_bits = ^{address_register[REG_WIDTH-1:AW], operand[12:AW]};

  // Host owns the port whenever the engine is not running.
  always_comb begin
    mem_we   = !running && (cmd_register == CMD_WRITE);
    mem_re   = running ? (state == ST_FETCH_I || state == ST_FETCH_C)
                       : (cmd_register == CMD_READ);
    mem_addr = address_register[AW-1:0];
    if (running) mem_addr = (state == ST_FETCH_C) ? cc[AW+1:2] : pc;
  end

  regex_mem #(.WORDS(MEM_WORDS), .WIDTH(REG_WIDTH), .AW(AW)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .re    (mem_re),
    .addr  (mem_addr),
    .wdata (data_in_register),
    .rdata (mem_rdata)
  );

  always_comb begin
    act = ACT_FAIL;
    unique case (op)
      OP_ACCEPT:         act = in_range ? ACT_FAIL : ACT_ACCEPT;
      OP_SPLIT:          act = ACT_PUSH;
      OP_MATCH:          act = (in_range && ch == operand[7:0]) ? ACT_ADV : ACT_FAIL;
      OP_JMP:            act = ACT_JMP;
      OP_END:            act = ACT_FAIL;
      OP_MATCH_ANY:      act = in_range ? ACT_ADV : ACT_FAIL;
      OP_ACCEPT_PARTIAL: act = ACT_ACCEPT;
      OP_NOT_MATCH:      act = (in_range && ch != operand[7:0]) ? ACT_ADV : ACT_FAIL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      status  <= STATUS_IDLE;
      state   <= ST_FETCH_I;
      sp      <= '0;
      elapsed <= '0;
      pc      <= '0;
      cc      <= '0;
      instr   <= '0;
      ch      <= '0;
    end else if (cmd_register == CMD_RESET) begin
      status <= STATUS_IDLE;
      sp     <= '0;
    end else if (status == STATUS_IDLE && cmd_register == CMD_START) begin
      status  <= STATUS_RUNNING;
      state   <= ST_FETCH_I;
      pc      <= '0;
      cc      <= start_cc_pointer_register;
      sp      <= '0;
      elapsed <= '0;
    end else if (running) begin
      elapsed <= elapsed + 1'b1;
      case (state)
        ST_FETCH_I: state <= ST_WAIT_I;
        ST_WAIT_I: begin
          instr <= mem_rdata[INSTRUCTION_WIDTH-1:0];
          state <= needs_char(opcode_e'(mem_rdata[15:13])) ? ST_FETCH_C : ST_EXEC;
        end
        ST_FETCH_C: state <= ST_WAIT_C;
        ST_WAIT_C: begin
          ch    <= 8'(mem_rdata >> {cc[1:0], 3'b000});
          state <= ST_EXEC;
        end
        ST_EXEC: begin
          state <= ST_FETCH_I;
          case (act)
            ACT_ADV: begin
              pc <= pc + 1'b1;
              cc <= cc + 1'b1;
            end
            ACT_JMP: pc <= operand[AW-1:0];
            ACT_PUSH: begin
              if (sp == SP_FULL) status <= STATUS_ERROR;
              else begin
                stack[sp[SW-1:0]] <= '{pc: operand[AW-1:0], cc: cc};
                sp <= sp + 1'b1;
                pc <= pc + 1'b1;
              end
            end
            ACT_ACCEPT: status <= STATUS_ACCEPTED;
            default: begin
              if (sp != '0) begin
                pc <= stack[sp_dec[SW-1:0]].pc;
                cc <= stack[sp_dec[SW-1:0]].cc;
                sp <= sp_dec;
              end else status <= STATUS_REJECTED;
            end
          endcase
        end
        default: state <= ST_FETCH_I;
      endcase
    end
  end

  // A host READ shows the RAM output for one cycle, then it is captured so
  // later engine fetches cannot disturb the read-back value.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_reg <= '0;
      sel_mem  <= 1'b0;
    end else if (cmd_register == CMD_READ_ELAPSED_CLOCK) begin
      data_reg <= elapsed;
      sel_mem  <= 1'b0;
    end else if (cmd_register == CMD_READ && !running) begin
      sel_mem <= 1'b1;
    end else if (sel_mem) begin
      data_reg <= mem_rdata;
      sel_mem  <= 1'b0;
    end
  end

  assign data_o_register = sel_mem ? mem_rdata : data_reg;
  assign status_register = {{(REG_WIDTH-3){1'b0}}, status};
endmodule

// File: tb/tb_axi_top.sv
// Randomized bench for axi_top: directed register/regex runs plus random
// forward-only programs scored against a queue-based backtracking interpreter.
module tb_axi_top;
  localparam logic [31:0] C_NOP = 0, C_WRITE = 1, C_START = 2, C_READ = 3,
                          C_RESET = 4, C_ELAPSED = 5;
  localparam logic [31:0] S_IDLE = 0, S_ACC = 1, S_REJ = 2, S_ERR = 3, S_RUN = 4;

  logic        clk = 1'b0, rst;
  logic [31:0] din, addr, spt, ept, cmd;
  logic [31:0] status, dout;
  logic [31:0] shadow [1024];
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  axi_top dut (
    .clk                       (clk),
    .rst                       (rst),
    .data_in_register          (din),
    .address_register          (addr),
    .start_cc_pointer_register (spt),
    .end_cc_pointer_register   (ept),
    .cmd_register              (cmd),
    .status_register           (status),
    .data_o_register           (dout)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] c);
    cmd = c;
    tick();
    cmd = C_NOP;
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    addr = a; din = d;
    issue(C_WRITE);
    shadow[a] = d;
  endtask

  task automatic rd_check(input string tag, input int a);
    addr = a;
    issue(C_READ);
    chk(tag, dout, shadow[a]);
  endtask

  // Interpreter: explicit thread list, each instruction costs fetch+wait+exec,
  // plus a two-cycle char fetch for the consuming opcodes.
  function automatic void model(input int s, input int e, output int res, output int cyc);
    int pcs[$];
    int ccs[$];
    int pc, cc, op, opd;
    logic [7:0] ch;
    bit fail;
    pc = 0; cc = s; cyc = 0; res = -1;
    while (cyc < 20000) begin
      op  = int'(shadow[pc][15:13]);
      opd = int'(shadow[pc][12:0]);
      ch  = 8'(shadow[(cc >> 2) % 1024] >> (8 * (cc % 4)));
      cyc += (op == 2 || op == 5 || op == 7) ? 5 : 3;
      fail = 0;
      case (op)
        0: if (cc > e) begin res = 1; return; end else fail = 1;
        1: if (pcs.size() >= 16) begin res = 3; return; end
           else begin pcs.push_back(opd % 1024); ccs.push_back(cc); pc = (pc + 1) % 1024; end
        2: if (cc <= e && int'(ch) == opd % 256) begin cc++; pc = (pc + 1) % 1024; end else fail = 1;
        3: pc = opd % 1024;
        4: fail = 1;
        5: if (cc <= e) begin cc++; pc = (pc + 1) % 1024; end else fail = 1;
        6: begin res = 1; return; end
        default: if (cc <= e && int'(ch) != opd % 256) begin cc++; pc = (pc + 1) % 1024; end else fail = 1;
      endcase
      if (fail) begin
        if (pcs.size() == 0) begin res = 2; return; end
        pc = pcs.pop_back();
        cc = ccs.pop_back();
      end
    end
  endfunction

  task automatic run(input string tag, input int s, input int e, input int hold);
    int res, cyc, n;
    model(s, e, res, cyc);
    spt = s; ept = e;
    cmd = C_START;
    tick();
    chk({tag, "_running"}, status, S_RUN);
    repeat (hold - 1) tick();
    cmd = C_NOP;
    n = 0;
    while (status == S_RUN && n < 20000) begin tick(); n++; end
    chk({tag, "_status"}, status, 32'(res));
    issue(C_ELAPSED);
    chk({tag, "_elapsed"}, dout, 32'(cyc));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int res, cyc, ok;
    logic [15:0] ins;
    foreach (shadow[i]) shadow[i] = '0;
    rst = 1; cmd = C_NOP; din = 0; addr = 0; spt = 0; ept = 0;
    repeat (3) tick();
    rst = 0;
    chk("rst_status", status, S_IDLE);
    chk("rst_data_o", dout, 0);
    issue(C_ELAPSED);
    chk("rst_elapsed", dout, 0);

    wr(6, 32'h12345678);
    wr(5, 32'hDEADBEEF);
    rd_check("rd_w5", 5);
    rd_check("rd_w6", 6);
    tick(); tick();
    chk("rd_hold", dout, 32'h12345678);

    // a(b|c)* over "abcb" with START held three cycles
    wr(0, 32'h4061); wr(1, 32'h2007); wr(2, 32'h2005); wr(3, 32'h4062);
    wr(4, 32'h6001); wr(5, 32'h4063); wr(6, 32'h6001); wr(7, 32'h0000);
    wr(8, 32'h62636261);
    run("abcb", 32, 35, 3);
    chk("abcb_nonzero", 32'(dout != 0), 1);
    repeat (4) tick();
    issue(C_ELAPSED);
    model(32, 35, res, cyc);
    chk("abcb_elapsed_stable", dout, 32'(cyc));
    issue(C_RESET);
    chk("reset_cmd_idle", status, S_IDLE);
    run("abcb_again", 32, 35, 1);

    issue(C_RESET);
    wr(8, 32'h00646261);
    run("abd", 32, 34, 1);

    issue(C_RESET);
    for (int i = 0; i < 17; i++) wr(i, 32'h2000 | 32'(i + 1));
    run("split17", 0, 0, 1);

    // infinite loop: host access blocked, RESET aborts
    issue(C_RESET);
    wr(0, 32'h6000);
    wr(100, 32'h11111111);
    rd_check("rd_w100", 100);
    spt = 0; ept = 0;
    issue(C_START);
    repeat (5) tick();
    addr = 100; din = 32'h22222222;
    issue(C_WRITE);
    addr = 8;
    issue(C_READ);
    chk("read_while_running", dout, 32'h11111111);
    chk("still_running", status, S_RUN);
    issue(C_RESET);
    chk("abort_idle", status, S_IDLE);
    rd_check("write_blocked", 100);

    for (int t = 0; t < 16; t++) begin
      int s, len;
      ok = 0;
      while (!ok) begin
        for (int i = 0; i < 16; i++) begin
          int r, tg;
          r  = $urandom_range(0, 9);
          tg = (i < 15) ? $urandom_range(15, i + 1) : 15;
          case (r)
            0, 1, 2, 3: ins = 16'h4000 | 16'(8'h61 + $urandom_range(0, 2));
            4:          ins = 16'hA000;
            5:          ins = 16'hE000 | 16'(8'h61 + $urandom_range(0, 2));
            6:          ins = 16'h2000 | 16'(tg);
            7:          ins = 16'h6000 | 16'(tg);
            8:          ins = 16'h0000;
            default:    ins = $urandom_range(0, 1) ? 16'h8000 : 16'hC000;
          endcase
          if (i == 15) ins = ($urandom_range(0, 1) != 0) ? 16'h0000 : 16'h8000;
          shadow[i] = {16'($urandom), ins};
        end
        for (int w = 32; w < 35; w++)
          for (int b = 0; b < 4; b++) shadow[w][8*b +: 8] = 8'h61 + 8'($urandom_range(0, 3));
        s   = 128 + $urandom_range(0, 2);
        len = $urandom_range(0, 8);
        model(s, s + len - 1, res, cyc);
        ok = (res > 0 && cyc < 1500) ? 1 : 0;
      end
      issue(C_RESET);
      for (int i = 0; i < 16; i++) wr(i, shadow[i]);
      for (int w = 32; w < 35; w++) wr(w, shadow[w]);
      run($sformatf("rnd%0d", t), s, s + len - 1, 1);
      rd_check($sformatf("rnd%0d_mem", t), $urandom_range(0, 15));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
